// File: rtl/ase_pcie_ss_rd_tag_mapper.sv
// DMA read-request tag mapper: hands out unique internal tags to AFU reads (whose tags may repeat)
// and restores the original AFU tag on each completion, freeing the internal tag on the last one.
module ase_pcie_ss_rd_tag_mapper #(
    parameter int unsigned NUM_TAGS  = 64,
    parameter int unsigned AFU_TAG_W = 10,
    localparam int unsigned TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 req_valid,
    input  logic [AFU_TAG_W-1:0] req_afu_tag,
    output logic                 req_ready,
    output logic [TAG_W-1:0]     req_tag,

    input  logic                 cpl_valid,
    input  logic [TAG_W-1:0]     cpl_tag,
    input  logic                 cpl_last,

    output logic                 cpl_out_valid,
    output logic [AFU_TAG_W-1:0] cpl_out_afu_tag,
    output logic                 cpl_out_last,
    output logic [TAG_W:0]       busy_cnt,
    output logic                 err_unalloc_cpl
);

    logic [NUM_TAGS-1:0]  busy_q, busy_d;
    logic [AFU_TAG_W-1:0] afu_tag_mem [NUM_TAGS];
    logic [TAG_W:0]       busy_cnt_q, busy_cnt_d;
    logic                 cpl_out_valid_q;
    logic [AFU_TAG_W-1:0] cpl_out_afu_tag_q;
    logic                 cpl_out_last_q;
    logic                 err_q;

    logic alloc;
    logic cpl_hit;
    logic free;

    assign req_ready = |(~busy_q);

    // Lowest-index free tag; scanning downward lets the lowest index win.
    always_comb begin
        req_tag = '0;
        for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                req_tag = TAG_W'(i);
            end
        end
    end

    assign alloc   = req_valid && req_ready;
    assign cpl_hit = cpl_valid && busy_q[cpl_tag];
    assign free    = cpl_hit && cpl_last;

    // An allocated tag is never busy, so it can never collide with a freed tag.
    always_comb begin
        busy_d = busy_q;
        if (alloc) begin
            busy_d[req_tag] = 1'b1;
        end
        if (free) begin
            busy_d[cpl_tag] = 1'b0;
        end
    end

    always_comb begin
        busy_cnt_d = busy_cnt_q;
        unique case ({alloc, free})
            2'b10:   busy_cnt_d = busy_cnt_q + 1'b1;
            2'b01:   busy_cnt_d = busy_cnt_q - 1'b1;
            default: busy_cnt_d = busy_cnt_q;
        endcase
    end

    // Only ever read for busy tags, so no reset is needed.
    always_ff @(posedge clk) begin
        if (alloc) begin
            afu_tag_mem[req_tag] <= req_afu_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q            <= '0;
            busy_cnt_q        <= '0;
            cpl_out_valid_q   <= 1'b0;
            cpl_out_afu_tag_q <= '0;
            cpl_out_last_q    <= 1'b0;
            err_q             <= 1'b0;
        end else begin
            busy_q          <= busy_d;
            busy_cnt_q      <= busy_cnt_d;
            cpl_out_valid_q <= cpl_hit;
            cpl_out_last_q  <= cpl_hit && cpl_last;
            if (cpl_hit) begin
                cpl_out_afu_tag_q <= afu_tag_mem[cpl_tag];
            end
            if (cpl_valid && !busy_q[cpl_tag]) begin
                err_q <= 1'b1;
            end
        end
    end

    assign cpl_out_valid   = cpl_out_valid_q;
    assign cpl_out_afu_tag = cpl_out_afu_tag_q;
    assign cpl_out_last    = cpl_out_last_q;
    assign busy_cnt        = busy_cnt_q;
    assign err_unalloc_cpl = err_q;

endmodule
